pe_seq_ctrl: RTL and testbench
==============================

Name: pe_seq_ctrl

Overview:
West-edge sequencer for a unary-rate systolic row.
- Drives the per-row control stream into the first border PE: en_i, clr_i, en_w, clr_w, en_o, clr_o and mac_done. It also issues read strobes to the weight and ifm buffers.
- Collects the returning mac_done / ofm from the far end of the row and presents results.
- Runs one weight load, then cfg_len input vectors. Each vector takes cfg_cyc bitstream cycles (early termination supported).

Parameters:
IWIDTH, 8, ifm/weight width incl. sign; full bitstream length = 2**(IWIDTH-1)
OWIDTH, 16, accumulator/ofm width
LWIDTH, 16, width of vector-count config and counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin a job when idle
cfg_len  in  LWIDTH  number of input vectors per job
cfg_cyc  in  IWIDTH  bitstream cycles per MAC; 0 means 2**(IWIDTH-1)
wght_rd  out  1  weight buffer read strobe (show-ahead, data valid same cycle)
ifm_rd  out  1  ifm buffer read strobe (show-ahead)
en_i, clr_i, en_w, clr_w, en_o, clr_o  out  1 each  PE control stream
mac_done  out  1  last bitstream cycle of a MAC
mac_done_ret  in  1  mac_done returned from the far-end PE
ofm_ret  in  OWIDTH signed  ofm from the far-end PE
res_valid  out  1  result strobe
res_data  out  OWIDTH signed  captured result
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end

Behaviour:
Output timing and reset
- All outputs are registered.
- Reset (async, any state) forces every output to 0, state to IDLE, and all counters to 0.
- Reset mid-job abandons the job. No done is produced.

Configuration and start
- cfg_len and cfg_cyc are latched on an accepted start.
- start is accepted only in IDLE. start while busy is ignored.
- cfg_cyc==0 is latched as 2**(IWIDTH-1).

States (cycle 0 = cycle in which start is sampled):
- IDLE: all control outputs low, busy=0. Accepted start -> CLR.
- CLR (cycle 1): clr_i=clr_w=clr_o=1, busy=1.
  - cfg_len==0 -> DONE.
  - Otherwise -> LDW.
- LDW (cycle 2): en_w=1, wght_rd=1 -> LDI.
- LDI: en_i=1, ifm_rd=1, clr_o=1 (clears the PE accumulator for the new vector). Bit counter cleared -> RUN.
- RUN: en_o=1 for exactly cyc cycles.
  - mac_done=1 on the last RUN cycle only.
  - Outstanding counter increments on that cycle.
  - Vector counter increments on that cycle.
  - If vectors issued < cfg_len -> LDI, else -> DRAIN.
  - Per-vector period is cyc+1 cycles.
  - First mac_done is at cycle 3+cyc.
- DRAIN: wait until the outstanding count reaches 0, then -> DONE.
- DONE: done=1 for one cycle; busy falls with it -> IDLE.

Outstanding counter (LWIDTH+1 bits)
- +1 on mac_done issued, -1 on mac_done_ret, unchanged if both occur in the same cycle.
- mac_done_ret with count 0 is a protocol error. The count saturates at 0 and a sticky error bit is set; the bit is internal only, visible to the bench by hierarchy.

Result capture
- On mac_done_ret, in any busy state, ofm_ret is registered into res_data.
- res_valid=1 in the following cycle.
- res_data holds its value until the next capture.
- Returns are accepted in RUN/LDI, overlapping issue.

Counters
- Vector counter wraps only via a clear at LDW. No wrap-around within a job.

Decomposition:
- Package pe_ctrl_pkg:
  - state enum (IDLE, CLR, LDW, LDI, RUN, DRAIN, DONE)
  - CYC_MAX = 2**(IWIDTH-1)
  - a function mapping cfg_cyc==0 to CYC_MAX
- One sub-module, pe_ret_tracker: outstanding up/down counter, error flag, and ofm capture register / res_valid.
- The FSM and the bit/vector counters stay in pe_seq_ctrl.

Test Plan:
1. Reset asserted mid-RUN (cfg_cyc=0) -> all outputs 0 immediately (asynchronously), busy=0. The next start runs a clean job.
2. cfg_len=1, cfg_cyc=4, start at cycle 0:
   - cycle 1: clr_* high
   - cycle 2: en_w/wght_rd high
   - cycle 3: en_i/ifm_rd/clr_o high
   - cycles 4-7: en_o high; mac_done at cycle 7
   - mac_done_ret with ofm_ret=16'h0123 at cycle 12 -> cycle 13: res_valid=1, res_data=16'h0123
   - done at cycle 14 (DRAIN sees count 0 at cycle 13)
3. cfg_len=3, cfg_cyc=0 -> en_o runs of 128 cycles; mac_done at cycles 131, 260, 389. Three returns produce three res_valid pulses with their respective data; done follows the last return.
4. cfg_len=2, cfg_cyc=2, first mac_done_ret coincides with the second mac_done issue -> outstanding count stays 1; done only after the second return.
5. cfg_len=0 -> CLR at cycle 1, done at cycle 2, no en_w/en_i/en_o or mac_done. A start pulse during busy in another job is ignored (no restart, cfg unchanged).
6. mac_done_ret in IDLE/DRAIN with count 0 -> count stays 0, error bit set, res_valid still pulses with the captured data.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the systolic row west-edge sequencer.
package pe_ctrl_pkg;

    localparam int IW_DEF  = 8;
    localparam int CYC_MAX = 2 ** (IW_DEF - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LDW,
        LDI,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // A zero cycle count selects the full bitstream length for width iw.
    function automatic int cyc_eff(input int cyc, input int iw);
        return (cyc == 0) ? 2 ** (iw - 1) : cyc;
    endfunction

endpackage

// File: rtl/pe_ret_tracker.sv
// Outstanding-MAC tracker and result capture for returns from the far-end PE.
module pe_ret_tracker #(
    parameter int OWIDTH = 16,
    parameter int LWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     dec,
    input  logic signed [OWIDTH-1:0] ofm_ret,
    output logic        [LWIDTH:0]   cnt,
    output logic                     err,
    output logic                     res_valid,
    output logic signed [OWIDTH-1:0] res_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (inc && !dec) begin
                cnt <= cnt + 1'b1;
            end else if (!inc && dec) begin
                // A return with nothing outstanding is a protocol error.
                if (cnt == '0) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            res_valid <= dec;
            if (dec) begin
                res_data <= ofm_ret;
            end
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// West-edge sequencer: weight load, then cfg_len vectors of cfg_cyc bit cycles.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int LWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic        [LWIDTH-1:0] cfg_len,
    input  logic        [IWIDTH-1:0] cfg_cyc,
    output logic                     wght_rd,
    output logic                     ifm_rd,
    output logic                     en_i,
    output logic                     clr_i,
    output logic                     en_w,
    output logic                     clr_w,
    output logic                     en_o,
    output logic                     clr_o,
    output logic                     mac_done,
    input  logic                     mac_done_ret,
    input  logic signed [OWIDTH-1:0] ofm_ret,
    output logic                     res_valid,
    output logic signed [OWIDTH-1:0] res_data,
    output logic                     busy,
    output logic                     done
);

    state_t              state;
    logic [LWIDTH-1:0]   len_q;
    logic [IWIDTH-1:0]   cyc_q;
    logic [IWIDTH-1:0]   bit_cnt;
    logic [LWIDTH-1:0]   vec_cnt;
    logic [LWIDTH-1:0]   vec_nxt;
    logic [IWIDTH-1:0]   bit_nxt;
    logic [LWIDTH:0]     out_cnt;
    logic                out_err;

    assign vec_nxt = vec_cnt + 1'b1;
    assign bit_nxt = bit_cnt + 1'b1;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            cyc_q    <= '0;
            bit_cnt  <= '0;
            vec_cnt  <= '0;
            wght_rd  <= 1'b0;
            ifm_rd   <= 1'b0;
            en_i     <= 1'b0;
            clr_i    <= 1'b0;
            en_w     <= 1'b0;
            clr_w    <= 1'b0;
            en_o     <= 1'b0;
            clr_o    <= 1'b0;
            mac_done <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wght_rd  <= 1'b0;
            ifm_rd   <= 1'b0;
            en_i     <= 1'b0;
            clr_i    <= 1'b0;
            en_w     <= 1'b0;
            clr_w    <= 1'b0;
            en_o     <= 1'b0;
            clr_o    <= 1'b0;
            mac_done <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= cfg_len;
                        cyc_q <= IWIDTH'(cyc_eff(int'(cfg_cyc), IWIDTH));
                        state <= CLR;
                        clr_i <= 1'b1;
                        clr_w <= 1'b1;
                        clr_o <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                CLR: begin
                    if (len_q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= LDW;
                        en_w    <= 1'b1;
                        wght_rd <= 1'b1;
                        vec_cnt <= '0;
                    end
                end
                LDW: begin
                    state   <= LDI;
                    en_i    <= 1'b1;
                    ifm_rd  <= 1'b1;
                    clr_o   <= 1'b1;
                    bit_cnt <= '0;
                end
                LDI: begin
                    state    <= RUN;
                    en_o     <= 1'b1;
                    bit_cnt  <= IWIDTH'(1);
                    mac_done <= (cyc_q == IWIDTH'(1));
                end
                RUN: begin
                    if (bit_cnt == cyc_q) begin
                        vec_cnt <= vec_nxt;
                        if (vec_nxt < len_q) begin
                            state   <= LDI;
                            en_i    <= 1'b1;
                            ifm_rd  <= 1'b1;
                            clr_o   <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        bit_cnt  <= bit_nxt;
                        en_o     <= 1'b1;
                        mac_done <= (bit_nxt == cyc_q);
                    end
                end
                DRAIN: begin
                    if (out_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pe_ret_tracker #(
        .OWIDTH(OWIDTH),
        .LWIDTH(LWIDTH)
    ) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (mac_done),
        .dec      (mac_done_ret),
        .ofm_ret  (ofm_ret),
        .cnt      (out_cnt),
        .err      (out_err),
        .res_valid(res_valid),
        .res_data (res_data)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: cycle table plus multi-cycle job scenarios.
module tb_pe_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [15:0]        cfg_len = '0;
    logic [7:0]         cfg_cyc = '0;
    logic               wght_rd, ifm_rd, en_i, clr_i, en_w, clr_w;
    logic               en_o, clr_o, mac_done;
    logic               mac_done_ret = 1'b0;
    logic signed [15:0] ofm_ret = '0;
    logic               res_valid;
    logic signed [15:0] res_data;
    logic               busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_cyc     (cfg_cyc),
        .wght_rd     (wght_rd),
        .ifm_rd      (ifm_rd),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .en_w        (en_w),
        .clr_w       (clr_w),
        .en_o        (en_o),
        .clr_o       (clr_o),
        .mac_done    (mac_done),
        .mac_done_ret(mac_done_ret),
        .ofm_ret     (ofm_ret),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done)
    );

    localparam logic [11:0] BY = 12'h800, DN = 12'h400, WR = 12'h200;
    localparam logic [11:0] IR = 12'h100, EI = 12'h080, CI = 12'h040;
    localparam logic [11:0] EW = 12'h020, CW = 12'h010, EO = 12'h008;
    localparam logic [11:0] CO = 12'h004, MD = 12'h002, RV = 12'h001;

    logic [11:0] ov;
    assign ov = {busy, done, wght_rd, ifm_rd, en_i, clr_i,
                 en_w, clr_w, en_o, clr_o, mac_done, res_valid};

    typedef struct {
        logic        st;
        logic        ret;
        logic [15:0] ofm;
        logic [11:0] eo;
        logic [15:0] ed;
    } vec_t;

    vec_t tv[16];

    int          md_q[$];
    logic [15:0] rv_q[$];
    int          eo_n, ew_n, ei_n, done_c, probe_v, probe_at;
    int          ret_c[$];
    logic [15:0] ret_d[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic job(input int len, input int cyc, input int re_at,
                       input int maxc);
        md_q.delete();
        rv_q.delete();
        eo_n = 0;
        ew_n = 0;
        ei_n = 0;
        done_c = -1;
        probe_v = -1;
        for (int c = 0; c < maxc && done_c < 0; c++) begin
            start = (c == 0) || (c == re_at);
            if (c == 0) begin
                cfg_len = 16'(len);
                cfg_cyc = 8'(cyc);
            end
            if (c == re_at) begin
                cfg_len = 16'd5;
                cfg_cyc = 8'd2;
            end
            mac_done_ret = 1'b0;
            ofm_ret = '0;
            if (ret_c.size() > 0 && ret_c[0] == c) begin
                mac_done_ret = 1'b1;
                ofm_ret = ret_d[0];
                void'(ret_c.pop_front());
                void'(ret_d.pop_front());
            end
            @(negedge clk);
            if (mac_done) md_q.push_back(c);
            if (en_o) eo_n++;
            if (en_w) ew_n++;
            if (en_i) ei_n++;
            if (res_valid) rv_q.push_back(res_data);
            if (c == probe_at) probe_v = int'(dut.u_trk.cnt);
            if (done) done_c = c;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        mac_done_ret = 1'b0;
        ofm_ret = '0;
    endtask

    task automatic setv(input int i, input logic st, input logic ret,
                        input logic [15:0] ofm, input logic [11:0] eo,
                        input logic [15:0] ed);
        tv[i] = '{st, ret, ofm, eo, ed};
    endtask

    initial begin
        for (int i = 0; i < 16; i++) setv(i, 0, 0, 16'h0, 12'h0, 16'h0);
        setv(0, 1, 0, 16'h0, 12'h0, 16'h0);
        setv(1, 0, 0, 16'h0, BY | CI | CW | CO, 16'h0);
        setv(2, 0, 0, 16'h0, BY | EW | WR, 16'h0);
        setv(3, 0, 0, 16'h0, BY | EI | IR | CO, 16'h0);
        for (int i = 4; i < 7; i++) setv(i, 0, 0, 16'h0, BY | EO, 16'h0);
        setv(7, 0, 0, 16'h0, BY | EO | MD, 16'h0);
        for (int i = 8; i < 12; i++) setv(i, 0, 0, 16'h0, BY, 16'h0);
        setv(12, 0, 1, 16'h0123, BY, 16'h0);
        setv(13, 0, 0, 16'h0, BY | RV, 16'h0123);
        setv(14, 0, 0, 16'h0, DN, 16'h0123);
        setv(15, 0, 0, 16'h0, 12'h0, 16'h0123);

        #12;
        chk("reset_outs", int'(ov), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-RUN after a stray return set err and res_data.
        cfg_len = 16'd2;
        cfg_cyc = 8'd0;
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            mac_done_ret = (c == 10);
            ofm_ret = (c == 10) ? 16'sh5A5A : 16'sh0;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        mac_done_ret = 1'b0;
        @(negedge clk);
        chk("t1_in_run", int'(en_o), 1);
        chk("t1_err_pre", int'(dut.u_trk.err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_outs", int'(ov), 0);
        chk("t1_res_data", int'(res_data), 0);
        chk("t1_err_clr", int'(dut.u_trk.err), 0);
        chk("t1_state", int'(dut.state), 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cycle-exact table: cfg_len=1, cfg_cyc=4.
        for (int i = 0; i < 16; i++) begin
            start = tv[i].st;
            mac_done_ret = tv[i].ret;
            ofm_ret = tv[i].ofm;
            cfg_len = 16'd1;
            cfg_cyc = 8'd4;
            @(negedge clk);
            chk($sformatf("t2_outs_c%0d", i), int'(ov), int'(tv[i].eo));
            chk($sformatf("t2_data_c%0d", i), int'(res_data), int'(tv[i].ed));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        mac_done_ret = 1'b0;

        // Full-length bitstream, three vectors.
        probe_at = -1;
        ret_c = '{140, 270, 400};
        ret_d = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
        job(3, 0, -1, 450);
        chk("t3_md_n", md_q.size(), 3);
        chk("t3_md0", md_q.size() > 0 ? md_q[0] : -1, 131);
        chk("t3_md1", md_q.size() > 1 ? md_q[1] : -1, 260);
        chk("t3_md2", md_q.size() > 2 ? md_q[2] : -1, 389);
        chk("t3_eo_n", eo_n, 384);
        chk("t3_ei_n", ei_n, 3);
        chk("t3_rv_n", rv_q.size(), 3);
        chk("t3_rv0", rv_q.size() > 0 ? int'(rv_q[0]) : -1, 16'h0AAA);
        chk("t3_rv1", rv_q.size() > 1 ? int'(rv_q[1]) : -1, 16'h0BBB);
        chk("t3_rv2", rv_q.size() > 2 ? int'(rv_q[2]) : -1, 16'h0CCC);
        chk("t3_done", done_c, 402);
        repeat (2) @(posedge clk);
        #1;

        // Return coincides with the second issue.
        probe_at = 9;
        ret_c = '{8, 11};
        ret_d = '{16'h0044, 16'h0055};
        job(2, 2, -1, 60);
        chk("t4_md0", md_q.size() > 0 ? md_q[0] : -1, 5);
        chk("t4_md1", md_q.size() > 1 ? md_q[1] : -1, 8);
        chk("t4_cnt_hold", probe_v, 1);
        chk("t4_rv_n", rv_q.size(), 2);
        chk("t4_done", done_c, 13);
        repeat (2) @(posedge clk);
        #1;

        // Empty job.
        probe_at = -1;
        job(0, 3, -1, 20);
        chk("t5_done", done_c, 2);
        chk("t5_md_n", md_q.size(), 0);
        chk("t5_en_n", eo_n + ew_n + ei_n, 0);
        repeat (2) @(posedge clk);
        #1;

        // Start while busy must be ignored.
        ret_c = '{10};
        ret_d = '{16'h0066};
        job(1, 4, 5, 60);
        chk("t5b_done", done_c, 12);
        chk("t5b_md_n", md_q.size(), 1);
        chk("t5b_md0", md_q.size() > 0 ? md_q[0] : -1, 7);
        chk("t5b_eo_n", eo_n, 4);
        chk("t5b_len_q", int'(dut.len_q), 1);
        chk("t5b_cyc_q", int'(dut.cyc_q), 4);
        cfg_len = '0;
        cfg_cyc = '0;
        repeat (2) @(posedge clk);
        #1;

        // Return in IDLE with nothing outstanding.
        chk("t6_err_pre", int'(dut.u_trk.err), 0);
        mac_done_ret = 1'b1;
        ofm_ret = 16'sh7777;
        @(posedge clk);
        #1;
        mac_done_ret = 1'b0;
        ofm_ret = '0;
        @(negedge clk);
        chk("t6_rv", int'(res_valid), 1);
        chk("t6_data", int'(res_data), 16'h7777);
        chk("t6_cnt", int'(dut.u_trk.cnt), 0);
        chk("t6_err", int'(dut.u_trk.err), 1);
        chk("t6_idle", int'(busy), 0);
        @(negedge clk);
        chk("t6_rv_low", int'(res_valid), 0);
        chk("t6_data_hold", int'(res_data), 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
